// File: rtl/control_unit_if.sv
// Control bundle between the multicycle control unit and its datapath.
// The master modport is the control unit; the slave modport is the datapath.
interface control_unit_if;
  logic [3:0] opcode;
  logic       compare;
  logic [1:0] Mux1_alu_B;
  logic [2:0] Mux2_alu_A;
  logic [1:0] Mux3_RF_wen;
  logic [2:0] Mux4_RF_wadd;
  logic [1:0] Mux5_RF_read2;
  logic       Mux6_RF_dataIn;
  logic [1:0] Mux8_memwrite;
  logic       Mux9_memDataIn;
  logic       CZ_en;
  logic       ALU_op;
  logic       memRead;
  logic       wIR;
  logic       wAtmp;
  logic       resetT1;
  logic [2:0] counter;
  logic       instr_done;

  modport master (
    input  opcode, compare,
    output Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2,
           Mux6_RF_dataIn, Mux8_memwrite, Mux9_memDataIn, CZ_en, ALU_op,
           memRead, wIR, wAtmp, resetT1, counter, instr_done
  );

  modport slave (
    output opcode, compare,
    input  Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2,
           Mux6_RF_dataIn, Mux8_memwrite, Mux9_memDataIn, CZ_en, ALU_op,
           memRead, wIR, wAtmp, resetT1, counter, instr_done
  );
endinterface

// File: rtl/control_unit.sv
// Moore-style multicycle control FSM for the 16-bit datapath.
// Define CTRL_BRANCH_EN to add BEQ/JAL/JLR; otherwise those opcodes run as NOP.
module control_unit #(
  parameter int MEM_WAIT = 0
) (
  input  logic            clk,
  input  logic            reset,
  control_unit_if.master  bus
);

  localparam logic [2:0] MEM_WAIT_W = 3'(MEM_WAIT);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;

  localparam logic [4:0] S_F0     = 5'd0;
  localparam logic [4:0] S_F1     = 5'd1;
  localparam logic [4:0] S_F2     = 5'd2;
  localparam logic [4:0] S_EX_ADD = 5'd3;
  localparam logic [4:0] S_EX_NDU = 5'd4;
  localparam logic [4:0] S_WB_R   = 5'd5;
  localparam logic [4:0] S_EX_ADI = 5'd6;
  localparam logic [4:0] S_WB_I   = 5'd7;
  localparam logic [4:0] S_EX_LHI = 5'd8;
  localparam logic [4:0] S_WB_L   = 5'd9;
  localparam logic [4:0] S_AD     = 5'd10;
  localparam logic [4:0] S_LD     = 5'd11;
  localparam logic [4:0] S_ST     = 5'd12;
  localparam logic [4:0] S_NP     = 5'd13;
`ifdef CTRL_BRANCH_EN
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  localparam logic [4:0] S_B0   = 5'd14;
  localparam logic [4:0] S_B1   = 5'd15;
  localparam logic [4:0] S_B2   = 5'd16;
  localparam logic [4:0] S_J0   = 5'd17;
  localparam logic [4:0] S_J1A  = 5'd18;
  localparam logic [4:0] S_J1R  = 5'd19;
  localparam logic [4:0] S_J2   = 5'd20;
`endif

  logic [4:0] state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       run_q, run_d;

  logic [1:0] mux1, mux3, mux5, mux8;
  logic [2:0] mux2, mux4;
  logic       mux6, mux9, cz_en, alu_op, mem_read, wir, done;

  function automatic logic is_mem_state(input logic [4:0] s);
    return (s == S_F1) || (s == S_LD) || (s == S_ST);
  endfunction

  // Next-state and wait-counter logic; run_q holds F0 one extra cycle after reset release.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    run_d   = 1'b1;
    case (state_q)
      S_F0: begin
        if (run_q) state_d = S_F1;
        else       state_d = S_F0;
      end
      S_F1: begin
        if (wait_q == 3'd0) state_d = S_F2;
        else                wait_d  = wait_q - 3'd1;
      end
      S_F2: begin
        case (bus.opcode)
          OP_ADD:  state_d = S_EX_ADD;
          OP_NDU:  state_d = S_EX_NDU;
          OP_ADI:  state_d = S_EX_ADI;
          OP_LHI:  state_d = S_EX_LHI;
          OP_LW:   state_d = S_AD;
          OP_SW:   state_d = S_AD;
`ifdef CTRL_BRANCH_EN
          OP_BEQ:  state_d = S_B0;
          OP_JAL:  state_d = S_J0;
          OP_JLR:  state_d = S_J0;
`endif
          default: state_d = S_NP;
        endcase
      end
      S_EX_ADD, S_EX_NDU: state_d = S_WB_R;
      S_EX_ADI:           state_d = S_WB_I;
      S_EX_LHI:           state_d = S_WB_L;
      S_AD: begin
        if (bus.opcode == OP_SW) state_d = S_ST;
        else                     state_d = S_LD;
      end
      S_LD, S_ST: begin
        if (wait_q == 3'd0) state_d = S_F0;
        else                wait_d  = wait_q - 3'd1;
      end
`ifdef CTRL_BRANCH_EN
      S_B0: begin
        if (bus.compare) state_d = S_B1;
        else             state_d = S_F0;
      end
      S_B1: state_d = S_B2;
      S_J0: begin
        if (bus.opcode == OP_JLR) state_d = S_J1R;
        else                      state_d = S_J1A;
      end
      S_J1A, S_J1R: state_d = S_J2;
      S_B2, S_J2:   state_d = S_F0;
`endif
      default: state_d = S_F0;
    endcase
    // Every entry into a memory state restarts the wait count.
    if ((state_d != state_q) && is_mem_state(state_d)) wait_d = MEM_WAIT_W;
    else                                               wait_d = wait_d;
  end

  // State, wait counter and post-reset hold flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_F0;
      wait_q  <= 3'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      run_q   <= run_d;
    end
  end

  // Moore output decode; only BEQ completion looks at compare.
  always_comb begin
    mux1     = 2'd0;
    mux2     = 3'd0;
    mux3     = 2'd0;
    mux4     = 3'd0;
    mux5     = 2'd0;
    mux6     = 1'b0;
    mux8     = 2'd0;
    mux9     = 1'b0;
    cz_en    = 1'b0;
    alu_op   = 1'b0;
    mem_read = 1'b0;
    wir      = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_F0: begin
        mux5 = 2'd2; mux1 = 2'd2; mux2 = 3'd0;
      end
      S_F1: begin
        mem_read = 1'b1; wir = 1'b1; mux5 = 2'd2; mux1 = 2'd2; mux2 = 3'd1;
      end
      S_F2: begin
        mux4 = 3'd3; mux3 = 2'd1; mux6 = 1'b1;
      end
      S_EX_ADD: begin
        mux2 = 3'd5; mux1 = 2'd2; cz_en = 1'b1; alu_op = 1'b0;
      end
      S_EX_NDU: begin
        mux2 = 3'd5; mux1 = 2'd2; cz_en = 1'b1; alu_op = 1'b1;
      end
      S_WB_R: begin
        mux4 = 3'd1; mux3 = 2'd2; mux6 = 1'b1; done = 1'b1;
      end
      S_EX_ADI: begin
        mux2 = 3'd5; mux1 = 2'd3; cz_en = 1'b1;
      end
      S_WB_I: begin
        mux4 = 3'd4; mux3 = 2'd1; mux6 = 1'b1; done = 1'b1;
      end
      S_EX_LHI: begin
        mux2 = 3'd2; mux1 = 2'd0;
      end
      S_WB_L: begin
        mux4 = 3'd0; mux3 = 2'd1; mux6 = 1'b1; done = 1'b1;
      end
      S_AD: begin
        mux5 = 2'd0; mux1 = 2'd2; mux2 = 3'd3;
      end
      S_LD: begin
        mem_read = 1'b1; mux4 = 3'd0; mux3 = 2'd1; mux6 = 1'b0;
        done = (wait_q == 3'd0);
      end
      S_ST: begin
        mux8 = 2'd1; mux9 = 1'b0;
        done = (wait_q == 3'd0);
      end
      S_NP: done = 1'b1;
`ifdef CTRL_BRANCH_EN
      S_B0: begin
        mux5 = 2'd0; mux1 = 2'd2; mux2 = 3'd5; done = ~bus.compare;
      end
      S_B1: begin
        mux5 = 2'd2; mux1 = 2'd2; mux2 = 3'd3;
      end
      S_J0: begin
        mux5 = 2'd2; mux1 = 2'd2; mux2 = 3'd0;
      end
      S_J1A: begin
        mux4 = 3'd0; mux3 = 2'd1; mux6 = 1'b1; mux5 = 2'd2; mux1 = 2'd2; mux2 = 3'd4;
      end
      S_J1R: begin
        mux4 = 3'd0; mux3 = 2'd1; mux6 = 1'b1; mux5 = 2'd0; mux1 = 2'd2; mux2 = 3'd0;
      end
      // B2 and J2 both restore R7 from T1, so the link written in J1 is overwritten when ra is R7.
      S_B2, S_J2: begin
        mux4 = 3'd3; mux3 = 2'd1; mux6 = 1'b1; done = 1'b1;
      end
`endif
      default: done = 1'b0;
    endcase
  end

  assign bus.Mux1_alu_B     = mux1;
  assign bus.Mux2_alu_A     = mux2;
  assign bus.Mux3_RF_wen    = mux3;
  assign bus.Mux4_RF_wadd   = mux4;
  assign bus.Mux5_RF_read2  = mux5;
  assign bus.Mux6_RF_dataIn = mux6;
  assign bus.Mux8_memwrite  = mux8;
  assign bus.Mux9_memDataIn = mux9;
  assign bus.CZ_en          = cz_en;
  assign bus.ALU_op         = alu_op;
  assign bus.memRead        = mem_read;
  assign bus.wIR            = wir;
  assign bus.wAtmp          = 1'b0;
  assign bus.resetT1        = 1'b1;
  assign bus.counter        = 3'd0;
  assign bus.instr_done     = done;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench: two control units (MEM_WAIT 0 and 2) checked cycle by cycle
// against per-instruction expected control-word sequences, with random async resets.
module tb_control_unit;

  logic clk = 1'b0;
  logic reset;

  control_unit_if if0 ();
  control_unit_if if2 ();

  control_unit #(.MEM_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  control_unit #(.MEM_WAIT(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  always #5 clk = ~clk;

  logic [25:0] obs [2];
  assign obs[0] = {if0.Mux1_alu_B, if0.Mux2_alu_A, if0.Mux3_RF_wen, if0.Mux4_RF_wadd,
                   if0.Mux5_RF_read2, if0.Mux6_RF_dataIn, if0.Mux8_memwrite, if0.Mux9_memDataIn,
                   if0.CZ_en, if0.ALU_op, if0.memRead, if0.wIR, if0.wAtmp, if0.resetT1,
                   if0.counter, if0.instr_done};
  assign obs[1] = {if2.Mux1_alu_B, if2.Mux2_alu_A, if2.Mux3_RF_wen, if2.Mux4_RF_wadd,
                   if2.Mux5_RF_read2, if2.Mux6_RF_dataIn, if2.Mux8_memwrite, if2.Mux9_memDataIn,
                   if2.CZ_en, if2.ALU_op, if2.memRead, if2.wIR, if2.wAtmp, if2.resetT1,
                   if2.counter, if2.instr_done};

  int vectors = 0;
  int miscompares = 0;

  logic [25:0] seq [2][0:19];
  int          len [2];
  int          pos [2];
  int          ninstr [2];
  logic [3:0]  cur_op [2];

  logic [3:0] dir_op  [0:11] = '{4'h0, 4'h2, 4'h1, 4'h3, 4'h4, 4'h5, 4'hC, 4'hC, 4'h8, 4'h9, 4'hF, 4'h6};
  logic       dir_cmp [0:11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic logic [25:0] cw(int m1, int m2, int m3, int m4, int m5, int m6, int m8,
                                     int m9, int cz, int alu, int mr, int wir, int done);
    return {2'(m1), 3'(m2), 2'(m3), 3'(m4), 2'(m5), 1'(m6), 2'(m8), 1'(m9),
            1'(cz), 1'(alu), 1'(mr), 1'(wir), 1'b0, 1'b1, 3'b000, 1'(done)};
  endfunction

  task automatic check_eq(input string tag, input logic [25:0] got, input logic [25:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %07h expected %07h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int d, input logic [25:0] w);
    seq[d][len[d]] = w;
    len[d]++;
  endtask

  // Expected control words for one instruction, straight from the per-opcode rules.
  task automatic build(input int d, input int mw, input logic [3:0] op, input logic c);
    logic br;
    len[d] = 0;
    pos[d] = 0;
`ifdef CTRL_BRANCH_EN
    br = 1'b1;
`else
    br = 1'b0;
`endif
    push(d, cw(2,0,0,0,2,0,0,0,0,0,0,0,0));
    for (int i = 0; i <= mw; i++) push(d, cw(2,1,0,0,2,0,0,0,0,0,1,1,0));
    push(d, cw(0,0,1,3,0,1,0,0,0,0,0,0,0));
    if (op == 4'h0 || op == 4'h2) begin
      push(d, cw(2,5,0,0,0,0,0,0,1,(op == 4'h2) ? 1 : 0,0,0,0));
      push(d, cw(0,0,2,1,0,1,0,0,0,0,0,0,1));
    end else if (op == 4'h1) begin
      push(d, cw(3,5,0,0,0,0,0,0,1,0,0,0,0));
      push(d, cw(0,0,1,4,0,1,0,0,0,0,0,0,1));
    end else if (op == 4'h3) begin
      push(d, cw(0,2,0,0,0,0,0,0,0,0,0,0,0));
      push(d, cw(0,0,1,0,0,1,0,0,0,0,0,0,1));
    end else if (op == 4'h4) begin
      push(d, cw(2,3,0,0,0,0,0,0,0,0,0,0,0));
      for (int i = 0; i <= mw; i++) push(d, cw(0,0,1,0,0,0,0,0,0,0,1,0,(i == mw) ? 1 : 0));
    end else if (op == 4'h5) begin
      push(d, cw(2,3,0,0,0,0,0,0,0,0,0,0,0));
      for (int i = 0; i <= mw; i++) push(d, cw(0,0,0,0,0,0,1,0,0,0,0,0,(i == mw) ? 1 : 0));
    end else if (br && op == 4'hC) begin
      push(d, cw(2,5,0,0,0,0,0,0,0,0,0,0,c ? 0 : 1));
      if (c) begin
        push(d, cw(2,3,0,0,2,0,0,0,0,0,0,0,0));
        push(d, cw(0,0,1,3,0,1,0,0,0,0,0,0,1));
      end
    end else if (br && (op == 4'h8 || op == 4'h9)) begin
      push(d, cw(2,0,0,0,2,0,0,0,0,0,0,0,0));
      if (op == 4'h8) push(d, cw(2,4,1,0,2,1,0,0,0,0,0,0,0));
      else            push(d, cw(2,0,1,0,0,1,0,0,0,0,0,0,0));
      push(d, cw(0,0,1,3,0,1,0,0,0,0,0,0,1));
    end else begin
      push(d, cw(0,0,0,0,0,0,0,0,0,0,0,0,1));
    end
  endtask

  task automatic start_instr(input int d);
    logic [3:0] op;
    logic       c;
    if (ninstr[d] < 12) begin
      op = dir_op[ninstr[d]];
      c  = dir_cmp[ninstr[d]];
    end else begin
      op = 4'($urandom_range(0, 15));
      c  = 1'($urandom_range(0, 1));
    end
    ninstr[d]++;
    cur_op[d] = op;
    if (d == 0) begin
      if0.opcode = op; if0.compare = c;
    end else begin
      if2.opcode = op; if2.compare = c;
    end
    build(d, (d == 0) ? 0 : 2, op, c);
  endtask

  initial begin
    int rst_left;
    logic [25:0] f0_word;
    f0_word = cw(2,0,0,0,2,0,0,0,0,0,0,0,0);
    reset = 1'b1;
    rst_left = 1;
    if0.opcode = 4'h0; if0.compare = 1'b0;
    if2.opcode = 4'h0; if2.compare = 1'b0;
    for (int d = 0; d < 2; d++) begin
      len[d] = 0; pos[d] = 0; ninstr[d] = 0; cur_op[d] = 4'h0;
    end
    #2;
    check_eq("reset_d0", obs[0], f0_word);
    check_eq("reset_d2", obs[1], f0_word);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      if (reset) begin
        if (rst_left == 0) begin
          reset = 1'b0;
          // Release cycle plus one more F0 before the next fetch begins.
          for (int d = 0; d < 2; d++) begin
            len[d] = 1; pos[d] = 0; seq[d][0] = f0_word;
          end
        end else begin
          rst_left--;
        end
      end else if (ninstr[0] > 12 && $urandom_range(0, 79) == 0) begin
        reset = 1'b1;
        rst_left = $urandom_range(0, 2);
      end
      if (!reset) begin
        for (int d = 0; d < 2; d++) if (pos[d] >= len[d]) start_instr(d);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          check_eq($sformatf("in_reset_d%0d", d), obs[d], f0_word);
        end else begin
          check_eq($sformatf("d%0d_op%h_step%0d", d, cur_op[d], pos[d]), obs[d], seq[d][pos[d]]);
          pos[d]++;
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
